// File: rtl/util_axis_1553_string_encoder_stream.sv
// Converts one 1553 word (16b data + sync/parity flags in tuser) into an ASCII
// text record "T:DIGITS S\r\n" and streams it out BUS_WIDTH bytes per beat.
module util_axis_1553_string_encoder_stream #(
  parameter int BUS_WIDTH = 1,
  parameter bit MODE_BIN  = 1'b0,
  parameter bit HEX_LOWER = 1'b0
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic [15:0]            s_axis_tdata,
  input  logic [7:0]             s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
  output logic [BUS_WIDTH-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int NDIG    = MODE_BIN ? 16 : 4;
  localparam int REC_LEN = NDIG + 6;
  localparam int BEATS   = (REC_LEN + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int CNT_W   = $clog2(BEATS) + 1;
  localparam int LAST_N  = REC_LEN - (BEATS - 1) * BUS_WIDTH;
  localparam int PAD_W   = BEATS * BUS_WIDTH * 8;
  localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(BEATS - 1);
  localparam logic [BUS_WIDTH-1:0] KEEP_LAST = BUS_WIDTH'((64'd1 << LAST_N) - 64'd1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rdy_en_q;
  logic [REC_LEN*8-1:0]   rec_q;
  logic                   load;
  logic                   fin;
  logic                   in_hs;
  logic                   out_hs;
  logic [PAD_W-1:0]       pad;
  logic                   unused_tuser;

  // tuser[4:1] carry no meaning for the text record
  assign unused_tuser = ^s_axis_tuser[4:1];

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)   return 8'h30 + {4'h0, n};
    else if (HEX_LOWER) return 8'h57 + {4'h0, n};
    else             return 8'h37 + {4'h0, n};
  endfunction

  // Character 0 lands in bits [7:0] so the first byte on the bus is the type letter
  function automatic logic [REC_LEN*8-1:0] build_rec(input logic [15:0] d,
                                                     input logic [2:0]  sync,
                                                     input logic        perr);
    logic [REC_LEN*8-1:0] r;
    logic [15:0]          sh;
    case (sync)
      3'b100:  r[7:0] = "C";
      3'b010:  r[7:0] = "D";
      default: r[7:0] = "?";
    endcase
    r[15:8] = ":";
    sh = d;
    for (int i = 0; i < NDIG; i++) begin
      if (MODE_BIN) begin
        r[(2+i)*8 +: 8] = sh[15] ? "1" : "0";
        sh = sh << 1;
      end else begin
        r[(2+i)*8 +: 8] = hex_char(sh[15:12]);
        sh = sh << 4;
      end
    end
    r[(2+NDIG)*8 +: 8] = " ";
    r[(3+NDIG)*8 +: 8] = perr ? "E" : "P";
    r[(4+NDIG)*8 +: 8] = 8'h0D;
    r[(5+NDIG)*8 +: 8] = 8'h0A;
    return r;
  endfunction

  assign fin           = (cnt_q == LAST_CNT);
  assign m_axis_tvalid = (state_q == SEND);
  // Accept the next word while idle, or in the same cycle the final beat leaves
  assign s_axis_tready = rdy_en_q & ((state_q == IDLE) | ((state_q == SEND) & fin & m_axis_tready));
  assign in_hs         = s_axis_tvalid & s_axis_tready;
  assign out_hs        = m_axis_tvalid & m_axis_tready;
  assign pad           = PAD_W'(rec_q);

  // Control state: FSM, beat counter and the post-reset ready enable
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Held record; contents are only observed while in SEND so no reset is needed
  always_ff @(posedge aclk) begin
    if (load) rec_q <= build_rec(s_axis_tdata, s_axis_tuser[7:5], s_axis_tuser[0]);
  end

  // Next state: load on input handshake, advance on output handshake, wrap at final beat
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_hs) begin
          if (fin) begin
            cnt_d = '0;
            if (in_hs) load = 1'b1;
            else       state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat slice of the zero-padded record; everything reads zero when idle
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    if (state_q == SEND) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt_q == CNT_W'(k)) m_axis_tdata = pad[k*BUS_WIDTH*8 +: BUS_WIDTH*8];
      end
      m_axis_tkeep = fin ? KEEP_LAST : '1;
      m_axis_tlast = fin;
    end
  end

endmodule

// File: tb/tb_util_axis_1553_string_encoder_stream.sv
// Bench for the 1553 string encoder: three instances (1-byte hex, 4-byte hex,
// 22-byte binary) driven from one stimulus process, checked by a scoreboard
// monitor against a string-formatting reference model.
module tb_util_axis_1553_string_encoder_stream;

  logic        aclk = 1'b0;
  logic        arstn;
  logic [15:0] s_tdata [3];
  logic [7:0]  s_tuser [3];
  logic [2:0]  s_tvalid;
  wire  [2:0]  s_tready;
  wire  [2:0]  m_tlast;
  wire  [2:0]  m_tvalid;
  logic [2:0]  m_tready;
  wire  [7:0]   td0;
  wire  [31:0]  td1;
  wire  [175:0] td2;
  wire  [0:0]   kp0;
  wire  [3:0]   kp1;
  wire  [21:0]  kp2;
  logic [175:0] m_tdata [3];
  logic [21:0]  m_tkeep [3];

  // scoreboard: accepted words logged by stimulus, consumed by the monitor
  logic [23:0] iss [3][1200];
  int          iss_n [3] = '{0, 0, 0};
  int          rdptr [3] = '{0, 0, 0};
  int          pos   [3] = '{0, 0, 0};
  string       cur   [3];
  int          n_chk = 0;
  int          n_fail = 0;
  int          tmo_cnt = 0;
  int          tmo_seen = 0;
  int          since_rst = 0;
  bit          final_req = 1'b0;
  bit          final_done = 1'b0;
  logic [2:0]  b2b = 3'b000;
  bit   [2:0]  rmode = 3'b000;

  always #5 aclk = ~aclk;

  util_axis_1553_string_encoder_stream #(.BUS_WIDTH(1), .MODE_BIN(1'b0), .HEX_LOWER(1'b0)) dut0 (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s_tdata[0]), .s_axis_tuser(s_tuser[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(td0), .m_axis_tkeep(kp0), .m_axis_tlast(m_tlast[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]));

  util_axis_1553_string_encoder_stream #(.BUS_WIDTH(4), .MODE_BIN(1'b0), .HEX_LOWER(1'b0)) dut1 (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s_tdata[1]), .s_axis_tuser(s_tuser[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(td1), .m_axis_tkeep(kp1), .m_axis_tlast(m_tlast[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]));

  util_axis_1553_string_encoder_stream #(.BUS_WIDTH(22), .MODE_BIN(1'b1), .HEX_LOWER(1'b0)) dut2 (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s_tdata[2]), .s_axis_tuser(s_tuser[2]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
    .m_axis_tdata(td2), .m_axis_tkeep(kp2), .m_axis_tlast(m_tlast[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready[2]));

  always_comb begin
    m_tdata[0] = 176'(td0);
    m_tdata[1] = 176'(td1);
    m_tdata[2] = td2;
    m_tkeep[0] = 22'(kp0);
    m_tkeep[1] = 22'(kp1);
    m_tkeep[2] = kp2;
  end

  function automatic int bw_of(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      default: return 22;
    endcase
  endfunction

  // Reference model: the whole record as a text string
  function automatic string rec_str(input logic [2:0] ty, input bit perr,
                                    input logic [15:0] d, input bit bin);
    string t, dig, st;
    if (ty == 3'b100)      t = "C";
    else if (ty == 3'b010) t = "D";
    else                   t = "?";
    if (bin) dig = $sformatf("%016b", d);
    else begin
      dig = $sformatf("%04h", d);
      dig = dig.toupper();
    end
    st = perr ? "E" : "P";
    return {t, ":", dig, " ", st, "\015\012"};
  endfunction

  // Output ready pattern: constant 1 or 50% random per instance
  initial begin
    m_tready = 3'b111;
    forever begin
      @(posedge aclk);
      #1;
      for (int g = 0; g < 3; g++) m_tready[g] = rmode[g] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every presented beat against the model, checks reset and stall behaviour
  initial begin : mon
    int           bw, len, n;
    logic [175:0] ed;
    logic [21:0]  ek;
    logic         el;
    logic [175:0] pd [3];
    logic [21:0]  pk [3];
    bit   [2:0]   pl;
    bit   [2:0]   stall;
    stall = 3'b000;
    pl    = 3'b000;
    forever begin
      @(negedge aclk);
      if (tmo_seen != tmo_cnt) begin
        n_chk++; n_fail++; tmo_seen++;
        $display("FAIL timeout: wait bound expired (count %0d), required none", tmo_seen);
      end
      if (!arstn) begin
        for (int g = 0; g < 3; g++) begin
          n_chk++;
          if (m_tvalid[g] !== 1'b0 || m_tlast[g] !== 1'b0 || m_tdata[g] !== '0 ||
              m_tkeep[g] !== '0 || s_tready[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out dut%0d: vld=%b last=%b keep=%h data=%h s_rdy=%b, required all 0",
                     g, m_tvalid[g], m_tlast[g], m_tkeep[g], m_tdata[g], s_tready[g]);
          end
          pos[g] = 0; rdptr[g] = iss_n[g]; stall[g] = 1'b0;
        end
        since_rst = 0;
      end else begin
        if (since_rst < 2) begin
          for (int g = 0; g < 3; g++) begin
            n_chk++;
            if (s_tready[g] !== (since_rst == 1)) begin
              n_fail++;
              $display("FAIL rdy_after_reset dut%0d cycle %0d: s_rdy=%b, required %b",
                       g, since_rst, s_tready[g], since_rst == 1);
            end
          end
          since_rst++;
        end
        for (int g = 0; g < 3; g++) begin
          bw = bw_of(g);
          if (stall[g]) begin
            n_chk++;
            if (m_tvalid[g] !== 1'b1 || m_tdata[g] !== pd[g] || m_tkeep[g] !== pk[g] || m_tlast[g] !== pl[g]) begin
              n_fail++;
              $display("FAIL stall_hold dut%0d: vld=%b data=%h keep=%h last=%b, required vld=1 data=%h keep=%h last=%b",
                       g, m_tvalid[g], m_tdata[g], m_tkeep[g], m_tlast[g], pd[g], pk[g], pl[g]);
            end
          end else if (pos[g] != 0) begin
            n_chk++;
            if (m_tvalid[g] !== 1'b1) begin
              n_fail++;
              $display("FAIL mid_record_valid dut%0d char %0d: vld=%b, required 1", g, pos[g], m_tvalid[g]);
            end
          end
          if (b2b[g]) begin
            n_chk++;
            if (m_tvalid[g] !== 1'b1) begin
              n_fail++;
              $display("FAIL back_to_back dut%0d: vld=%b, required 1", g, m_tvalid[g]);
            end
          end
          if (m_tvalid[g] === 1'b1 && m_tready[g] === 1'b1) begin
            if (pos[g] == 0) begin
              if (rdptr[g] < iss_n[g]) begin
                cur[g] = rec_str(iss[g][rdptr[g]][23:21], iss[g][rdptr[g]][16], iss[g][rdptr[g]][15:0], g == 2);
                rdptr[g]++;
              end else cur[g] = "";
            end
            len = cur[g].len();
            n_chk++;
            if (len == 0) begin
              n_fail++;
              $display("FAIL spurious_beat dut%0d: data=%h keep=%h, required no beat", g, m_tdata[g], m_tkeep[g]);
            end else begin
              n = (len - pos[g] < bw) ? len - pos[g] : bw;
              ed = '0; ek = '0;
              for (int b = 0; b < n; b++) begin
                ed[b*8 +: 8] = cur[g][pos[g] + b];
                ek[b] = 1'b1;
              end
              el = (pos[g] + n == len);
              if (m_tdata[g] !== ed || m_tkeep[g] !== ek || m_tlast[g] !== el) begin
                n_fail++;
                $display("FAIL beat dut%0d rec %0d char %0d: data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                         g, rdptr[g] - 1, pos[g], m_tdata[g], m_tkeep[g], m_tlast[g], ed, ek, el);
              end
              pos[g] += n;
              if (pos[g] == len) pos[g] = 0;
            end
          end
          stall[g] = (m_tvalid[g] === 1'b1) && (m_tready[g] === 1'b0);
          pd[g] = m_tdata[g]; pk[g] = m_tkeep[g]; pl[g] = m_tlast[g];
        end
      end
      if (final_req && !final_done) begin
        for (int g = 0; g < 3; g++) begin
          n_chk++;
          if (rdptr[g] != iss_n[g] || pos[g] != 0) begin
            n_fail++;
            $display("FAIL leftover dut%0d: emitted %0d of %0d records (pos %0d), required all emitted",
                     g, rdptr[g], iss_n[g], pos[g]);
          end
        end
        final_done = 1'b1;
      end
    end
  end

  task automatic send(input int g, input logic [15:0] d, input logic [7:0] u, input bit hold);
    bit acc;
    acc = 1'b0;
    s_tdata[g]  = d;
    s_tuser[g]  = u;
    s_tvalid[g] = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge aclk);
      acc = s_tready[g];
      @(posedge aclk);
    end
    if (acc) begin
      iss[g][iss_n[g]] = {u, d};
      iss_n[g]++;
    end else tmo_cnt++;
    #1;
    if (!hold) s_tvalid[g] = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 20000 && !(rdptr[0] == iss_n[0] && pos[0] == 0 &&
                          rdptr[1] == iss_n[1] && pos[1] == 0 &&
                          rdptr[2] == iss_n[2] && pos[2] == 0)) begin
      @(posedge aclk);
      k++;
    end
    if (k >= 20000) tmo_cnt++;
    repeat (3) @(posedge aclk);
    #1;
  endtask

  function automatic logic [7:0] rand_user();
    int pick;
    logic [2:0] ty;
    pick = $urandom_range(0, 2);
    ty = (pick == 0) ? 3'b100 : (pick == 1) ? 3'b010 : 3'($urandom);
    return {ty, 5'($urandom)};
  endfunction

  initial begin
    int hs;
    logic [15:0] base;
    arstn = 1'b0;
    s_tvalid = 3'b000;
    for (int g = 0; g < 3; g++) begin
      s_tdata[g] = '0;
      s_tuser[g] = '0;
    end
    repeat (3) @(posedge aclk);
    #1 arstn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // directed records on each bus width
    send(0, 16'h1A2B, 8'h40, 1'b0);
    send(1, 16'hBEEF, 8'h81, 1'b0);
    send(2, 16'h8001, 8'h20, 1'b0);
    drain();

    // continuous input and output: records must follow with no bubble
    send(0, 16'h0000, 8'h80, 1'b1);
    b2b[0] = 1'b1;
    for (int i = 1; i < 20; i++) send(0, 16'(i), 8'h40, 1'b1);
    send(0, 16'h0014, 8'h81, 1'b0);
    b2b[0] = 1'b0;
    drain();

    // random output backpressure, incrementing data, occasional input gaps
    rmode = 3'b111;
    base = 16'($urandom);
    for (int i = 0; i < 1000; i++) begin
      send(1, base + 16'(i), rand_user(), 1'b0);
      if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
    end
    for (int i = 0; i < 100; i++) begin
      send(0, base + 16'(i * 7), rand_user(), 1'b0);
      send(2, 16'($urandom), rand_user(), 1'b0);
    end
    drain();
    rmode = 3'b000;
    repeat (2) @(posedge aclk);
    #1;

    // reset in the middle of a record, then a fresh record
    send(0, 16'hC0DE, 8'h41, 1'b0);
    hs = 0;
    for (int k = 0; k < 100 && hs < 4; k++) begin
      @(negedge aclk);
      if (m_tvalid[0] && m_tready[0]) hs++;
      @(posedge aclk);
    end
    if (hs < 4) tmo_cnt++;
    #1 arstn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 arstn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    send(0, 16'h5A5A, 8'h40, 1'b0);
    send(1, 16'h0F0F, 8'h21, 1'b0);
    send(2, 16'hFFFE, 8'h81, 1'b0);
    drain();

    final_req = 1'b1;
    for (int k = 0; k < 10 && !final_done; k++) @(posedge aclk);
    if (!final_done) begin
      $display("FAIL final_check: monitor did not complete, required completion");
      $fatal(1, "monitor did not complete");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
